dac_reg_spi_rx: RTL and testbench
=================================

Name: dac_reg_spi_rx

Overview:
- Upstream stage of the DAC polling engine: receives channel set-points from the AR9331 over a 3-wire SPI link (AR9331 is master, this block is slave).
- Holds them in an 8-entry x 12-bit register bank.
- The polling engine reads the bank by HC4051 mux position and feeds each value to the AD5320 in turn.
- All logic runs on the core clock; SPI inputs are oversampled, not used as clocks.

Parameters:
- CH_NUM, 8, number of mux channels / bank entries.
- DATA_W, 12, DAC code width.
- RST_CODE, 2048, bank reset value (mid-scale).
- FRAME_W, 16, SPI frame length in bits.

Ports:
- clk  in  1  core clock. One clock only; must be at least 8x the SPI SCLK rate.
- rst_n  in  1  synchronous active-low reset.
- en  in  1  receive enable.
- spi_sclk  in  1  SPI clock from AR9331 (mode 0).
- spi_mosi  in  1  SPI data, MSB first.
- spi_cs_n  in  1  SPI chip select, active low.
- rd_pos  in  3  channel index requested by the polling stage.
- rd_data  out  12  bank[rd_pos], registered.
- dirty  out  8  per-channel "written since last clear" flags.
- dirty_clr  in  8  per-channel clear strobes.
- frame_done  out  1  one-cycle pulse on each valid committed write.
- frame_err  out  1  one-cycle pulse on each rejected frame.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - all bank entries = RST_CODE;
  - rd_data = RST_CODE;
  - dirty = 0, frame_done = 0, frame_err = 0;
  - FSM = IDLE, bit counter = 0;
  - synchronizer flops = idle levels (sclk 0, cs_n 1, mosi 0).
- Input conditioning:
  - 2-FF synchronizer on each of sclk, mosi, cs_n.
  - Edge detect on the synchronized signals; a third flop stage holds the previous value.
  - Sampling point: synchronized sclk rising edge.
- Frame format (16 bits, MSB first):
  - [15] = must be 0 (1 = reserved, treated as error);
  - [14:12] = channel;
  - [11:0] = code.
- FSM states: IDLE, SHIFT, OVERRUN, COMMIT.
  - IDLE: cs_n falling edge with en=1 -> SHIFT; clear shift register and counter.
  - SHIFT: each sclk rising edge shifts mosi into the LSB and increments the counter (saturating at 16 via the state change).
    - 17th sclk rising edge -> OVERRUN.
    - cs_n rising edge with counter = 16 -> COMMIT.
    - cs_n rising edge with counter != 16 -> IDLE, frame_err pulse, no write.
  - OVERRUN: remain until cs_n rising edge -> IDLE, frame_err pulse, no write.
  - COMMIT (one cycle), then always -> IDLE:
    - if bit15 = 0: bank[ch] <= code, dirty[ch] <= 1, frame_done pulse;
    - else: frame_err pulse only.
- en=0 in any state:
  - FSM forced to IDLE the next cycle;
  - partial frame discarded, no frame_err;
  - bank, dirty and rd_data reads unaffected.
- Read port:
  - rd_data <= bank[rd_pos] every cycle, so latency is 1 clk.
  - Read and write to the same channel in the same cycle: rd_data shows the old value that cycle and the new value one cycle later.
- Dirty flags:
  - dirty_clr[i] clears dirty[i] at the next edge.
  - Simultaneous COMMIT write and clear on the same channel: set wins (dirty stays 1).
- A cs_n falling edge during COMMIT is ignored; the master must keep CS high for at least 4 clk between frames.

Optional Feature:
- Macro: DAC_REG_READBACK_EN.
- With the macro defined:
  - adds output spi_miso (1 bit, reset 0).
  - On cs_n falling edge, a 16-bit shadow is loaded with {4'b0, bank[last written channel]}.
  - The shadow shifts out MSB first, updating on ssynchronized sclk falling edges.
  - After 16 bits, spi_miso holds 0.
  - Last-written channel register resets to 0.
- Without it: no spi_miso port and no shadow logic.

Decomposition:
- Package dac_reg_pkg:
  - CH_NUM, DATA_W, FRAME_W, RST_CODE;
  - typedef ch_t (3-bit), code_t (12-bit);
  - enum state_t {IDLE, SHIFT, OVERRUN, COMMIT};
  - frame field bit positions.
- One sub-module, spi_in_sync: 2-FF synchronizer plus edge detector, instantiated for sclk, mosi and cs_n; outputs level, rise and fall.

Test Plan:
- Reset, then read rd_pos 0..7 -> rd_data = 2048 each, one cycle after rd_pos changes; dirty = 8'h00.
- Frame 16'h3ABC (ch 3, code 0xABC) -> one frame_done pulse after cs_n rises; bank[3] = 0xABC; dirty = 8'h08; all other channels stay 2048.
- Frames with 15 bits, with 17 bits, and 16'h8123 -> frame_err pulse each, no frame_done, bank and dirty unchanged.
- COMMIT to ch 5 in the same cycle as dirty_clr = 8'h20 and rd_pos = 5 -> dirty[5] = 1; rd_data shows the old value for 1 cycle, then the new value.
- en dropped after 8 bits of a frame, then restored, then a full frame 16'h1001 sent -> no frame_err for the aborted frame; bank[1] = 0x001.
- With DAC_REG_READBACK_EN: write 16'h6555, then run a second 16-clock frame -> spi_miso shifts out 16'h0555.

Source files
------------

// File: rtl/dac_reg_pkg.sv
// -----------------------------------------------------------------------------
// dac_reg_pkg
// Purpose : Shared sizes, types and frame field positions for the DAC
//           set-point SPI receiver (dac_reg_spi_rx) and its helpers.
// Ports   : none (package)
// -----------------------------------------------------------------------------
package dac_reg_pkg;

    localparam int unsigned CH_NUM  = 8;
    localparam int unsigned DATA_W  = 12;
    localparam int unsigned FRAME_W = 16;
    localparam int unsigned CH_W    = 3;
    localparam int unsigned CNT_W   = 5;

    typedef logic [CH_W-1:0]   ch_t;
    typedef logic [DATA_W-1:0] code_t;

    localparam code_t RST_CODE = 12'd2048;

    // Frame layout: [15] reserved (must be 0), [14:12] channel, [11:0] code
    localparam int unsigned FRM_RSV_BIT  = 15;
    localparam int unsigned FRM_CH_LSB   = 12;
    localparam int unsigned FRM_CODE_LSB = 0;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHIFT   = 2'd1,
        OVERRUN = 2'd2,
        COMMIT  = 2'd3
    } state_t;

endpackage

// File: rtl/spi_in_sync.sv
// -----------------------------------------------------------------------------
// spi_in_sync
// Purpose : 2-FF synchronizer for one SPI pin plus a third flop that holds the
//           previous synchronized value for edge detection.
// Ports   : i_clk      core clock
//           i_rst_n    synchronous active-low reset (flops go to IDLE_VAL)
//           i_async    asynchronous SPI pin
//           o_level    synchronized level (registered)
//           o_rise_c   one-cycle rising-edge strobe (combinational)
//           o_fall_c   one-cycle falling-edge strobe (combinational)
// -----------------------------------------------------------------------------
module spi_in_sync #(
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_level,
    output logic o_rise_c,
    output logic o_fall_c
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Synchronizer chain and history flop
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_meta <= IDLE_VAL;
            r_sync <= IDLE_VAL;
            r_prev <= IDLE_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level  = r_sync;
    assign o_rise_c = r_sync & ~r_prev;
    assign o_fall_c = ~r_sync & r_prev;

endmodule

// File: rtl/dac_reg_spi_rx.sv
// -----------------------------------------------------------------------------
// dac_reg_spi_rx
// Purpose : SPI slave that receives 16-bit channel set-point frames from the
//           AR9331 and stores them in an 8 x 12-bit register bank read by the
//           DAC polling engine. SPI pins are oversampled on the core clock.
// Ports   : i_clk         core clock (>= 8x SCLK)
//           i_rst_n       synchronous active-low reset
//           i_en          receive enable
//           i_spi_sclk    SPI clock, mode 0
//           i_spi_mosi    SPI data, MSB first
//           i_spi_cs_n    SPI chip select, active low
//           i_rd_pos      bank read index
//           o_rd_data     bank[i_rd_pos], one clock latency
//           o_dirty       per-channel written-since-clear flags
//           i_dirty_clr   per-channel clear strobes
//           o_frame_done  pulse per committed write
//           o_frame_err   pulse per rejected frame
//           o_spi_miso    readback data (only with DAC_REG_READBACK_EN)
// Macro   : DAC_REG_READBACK_EN adds o_spi_miso and the readback shadow.
// -----------------------------------------------------------------------------
module dac_reg_spi_rx
    import dac_reg_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_en,
    input  logic              i_spi_sclk,
    input  logic              i_spi_mosi,
    input  logic              i_spi_cs_n,
    input  logic [CH_W-1:0]   i_rd_pos,
    output logic [DATA_W-1:0] o_rd_data,
    output logic [CH_NUM-1:0] o_dirty,
    input  logic [CH_NUM-1:0] i_dirty_clr,
    output logic              o_frame_done,
    output logic              o_frame_err
`ifdef DAC_REG_READBACK_EN
    ,
    output logic              o_spi_miso
`endif
);

    // Conditioned SPI inputs
    logic w_sclk_lvl, w_sclk_rise_c, w_sclk_fall_c;
    logic w_mosi_lvl, w_mosi_rise_c, w_mosi_fall_c;
    logic w_cs_lvl,   w_cs_rise_c,   w_cs_fall_c;

    spi_in_sync #(.IDLE_VAL(1'b0)) u_sync_sclk (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_async  (i_spi_sclk),
        .o_level  (w_sclk_lvl),
        .o_rise_c (w_sclk_rise_c),
        .o_fall_c (w_sclk_fall_c)
    );

    spi_in_sync #(.IDLE_VAL(1'b0)) u_sync_mosi (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_async  (i_spi_mosi),
        .o_level  (w_mosi_lvl),
        .o_rise_c (w_mosi_rise_c),
        .o_fall_c (w_mosi_fall_c)
    );

    spi_in_sync #(.IDLE_VAL(1'b1)) u_sync_cs (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_async  (i_spi_cs_n),
        .o_level  (w_cs_lvl),
        .o_rise_c (w_cs_rise_c),
        .o_fall_c (w_cs_fall_c)
    );

    state_t               r_state, w_state_nxt;
    logic [FRAME_W-1:0]   r_shift, w_shift_nxt;
    logic [CNT_W-1:0]     r_cnt,   w_cnt_nxt;
    logic                 w_we;
    logic                 w_done_nxt;
    logic                 w_err_nxt;
    ch_t                  w_ch;
    code_t                w_code;
    logic [CH_NUM-1:0]    w_set;

    code_t                r_bank [CH_NUM];
    code_t                r_rd_data;
    logic [CH_NUM-1:0]    r_dirty;
    logic                 r_done;
    logic                 r_err;

    assign w_ch   = r_shift[FRM_CH_LSB +: CH_W];
    assign w_code = r_shift[FRM_CODE_LSB +: DATA_W];

    // Frame FSM: next state, shift/count update and commit decision
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
        w_we        = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        if (!i_en) begin
            // Disabling drops any partial frame silently
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_cs_fall_c) begin
                        w_state_nxt = SHIFT;
                        w_shift_nxt = '0;
                        w_cnt_nxt   = '0;
                    end
                end
                SHIFT: begin
                    if (w_cs_rise_c) begin
                        if (r_cnt == CNT_W'(FRAME_W)) begin
                            w_state_nxt = COMMIT;
                        end else begin
                            w_state_nxt = IDLE;
                            w_err_nxt   = 1'b1;
                        end
                    end else if (w_sclk_rise_c) begin
                        if (r_cnt == CNT_W'(FRAME_W)) begin
                            w_state_nxt = OVERRUN;
                        end else begin
                            w_shift_nxt = {r_shift[FRAME_W-2:0], w_mosi_lvl};
                            w_cnt_nxt   = r_cnt + CNT_W'(1);
                        end
                    end
                end
                OVERRUN: begin
                    if (w_cs_rise_c) begin
                        w_state_nxt = IDLE;
                        w_err_nxt   = 1'b1;
                    end
                end
                COMMIT: begin
                    w_state_nxt = IDLE;
                    if (!r_shift[FRM_RSV_BIT]) begin
                        w_we       = 1'b1;
                        w_done_nxt = 1'b1;
                    end else begin
                        w_err_nxt  = 1'b1;
                    end
                end
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // FSM state, shift register and status pulses
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_cnt   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_shift <= w_shift_nxt;
            r_cnt   <= w_cnt_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
        end
    end

    // Register bank and read port; a same-cycle read returns the old value
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                r_bank[i] <= RST_CODE;
            end
            r_rd_data <= RST_CODE;
        end else begin
            if (w_we) begin
                r_bank[w_ch] <= w_code;
            end
            r_rd_data <= r_bank[i_rd_pos];
        end
    end

    // Dirty flags: a commit set overrides a same-cycle clear
    assign w_set = w_we ? (CH_NUM'(1) << w_ch) : '0;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_dirty <= '0;
        end else begin
            r_dirty <= (r_dirty & ~i_dirty_clr) | w_set;
        end
    end

    assign o_rd_data    = r_rd_data;
    assign o_dirty      = r_dirty;
    assign o_frame_done = r_done;
    assign o_frame_err  = r_err;

`ifdef DAC_REG_READBACK_EN
    ch_t                r_last_ch;
    logic [FRAME_W-1:0] r_rb_sh;
    logic               r_miso;
    logic [FRAME_W-1:0] w_rb_load;

    assign w_rb_load = FRAME_W'(r_bank[r_last_ch]);

    // Readback shadow: first bit presented at CS fall, rest on SCLK falls
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_last_ch <= '0;
            r_rb_sh   <= '0;
            r_miso    <= 1'b0;
        end else begin
            if (w_we) begin
                r_last_ch <= w_ch;
            end
            if (w_cs_fall_c) begin
                r_miso  <= w_rb_load[FRAME_W-1];
                r_rb_sh <= {w_rb_load[FRAME_W-2:0], 1'b0};
            end else if (w_sclk_fall_c && !w_cs_lvl) begin
                r_miso  <= r_rb_sh[FRAME_W-1];
                r_rb_sh <= {r_rb_sh[FRAME_W-2:0], 1'b0};
            end
        end
    end

    assign o_spi_miso = r_miso;

    logic w_unused;
    assign w_unused = &{1'b0, w_sclk_lvl, w_mosi_rise_c, w_mosi_fall_c};
`else
    logic w_unused;
    assign w_unused = &{1'b0, w_sclk_lvl, w_sclk_fall_c, w_cs_lvl,
                        w_mosi_rise_c, w_mosi_fall_c};
`endif

endmodule

// File: tb/tb_dac_reg_spi_rx.sv
// -----------------------------------------------------------------------------
// tb_dac_reg_spi_rx
// Purpose : Self-checking bench for dac_reg_spi_rx. A frame-level model of the
//           bank and dirty flags is compared with the DUT on every quiet cycle,
//           pulse counts are compared after each frame, and a few literal
//           expectations pin the model. DAC_REG_READBACK_EN enables the
//           readback check.
// -----------------------------------------------------------------------------
module tb_dac_reg_spi_rx;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_cs_n;
    logic [2:0]  rd_pos;
    logic [11:0] rd_data;
    logic [7:0]  dirty;
    logic [7:0]  dirty_clr;
    logic        frame_done;
    logic        frame_err;
`ifdef DAC_REG_READBACK_EN
    logic        spi_miso;
    logic [15:0] rb_cap;
`endif

    dac_reg_spi_rx u_dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_en         (en),
        .i_spi_sclk   (spi_sclk),
        .i_spi_mosi   (spi_mosi),
        .i_spi_cs_n   (spi_cs_n),
        .i_rd_pos     (rd_pos),
        .o_rd_data    (rd_data),
        .o_dirty      (dirty),
        .i_dirty_clr  (dirty_clr),
        .o_frame_done (frame_done),
        .o_frame_err  (frame_err)
`ifdef DAC_REG_READBACK_EN
        ,
        .o_spi_miso   (spi_miso)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model state
    logic [11:0] model_bank [8];
    logic [7:0]  model_dirty;
    int          exp_done;
    int          exp_err;
    int          n_done;
    int          n_err;

    int          checks;
    int          errors;
    bit          chk_en;
    bit          quiet;
    bit          rd_rand;
    logic [2:0]  rd_pos_s;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Advance n clocks; inputs change 1ns after the edge
    task automatic tick(input int n = 1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            rd_pos_s = rd_pos;
            #1;
            if (rd_rand) rd_pos = 3'($urandom);
        end
    endtask

    // Shift n bits of v MSB first with an 8-clock SCLK period
    task automatic send_bits(input logic [31:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            spi_mosi = v[i];
            tick(4);
`ifdef DAC_REG_READBACK_EN
            rb_cap = {rb_cap[14:0], spi_miso};
`endif
            spi_sclk = 1'b1;
            tick(4);
            spi_sclk = 1'b0;
        end
    endtask

    // Full CS-framed transfer, then update the model and check pulse counts
    task automatic frame(input logic [31:0] v, input int n);
        quiet = 1'b0;
        spi_cs_n = 1'b0;
        tick(4);
        send_bits(v, n);
        tick(4);
        spi_cs_n = 1'b1;
        tick(10);
        if (n == 16 && v[15] == 1'b0) begin
            model_bank[v[14:12]] = v[11:0];
            model_dirty[v[14:12]] = 1'b1;
            exp_done++;
        end else begin
            exp_err++;
        end
        chk("done_cnt", 32'(n_done), 32'(exp_done));
        chk("err_cnt", 32'(n_err), 32'(exp_err));
        quiet = 1'b1;
        tick(4);
    endtask

    task automatic clear_dirty(input logic [7:0] m);
        quiet = 1'b0;
        dirty_clr = m;
        tick(1);
        dirty_clr = 8'h00;
        model_dirty = model_dirty & ~m;
        quiet = 1'b1;
        tick(1);
    endtask

    task automatic read_chk(input string nm, input logic [2:0] ch, input logic [11:0] exp);
        bit save;
        save = rd_rand;
        rd_rand = 1'b0;
        rd_pos = ch;
        tick(1);
        chk(nm, 32'(rd_data), 32'(exp));
        rd_rand = save;
    endtask

    initial begin
        logic [31:0] v;
        int          n;
        int          r;
        bit          prev_done;
        bit          prev_err;

        checks = 0; errors = 0; chk_en = 1'b0; quiet = 1'b0; rd_rand = 1'b0;
        exp_done = 0; exp_err = 0; n_done = 0; n_err = 0;
        prev_done = 1'b0; prev_err = 1'b0;
        for (int i = 0; i < 8; i++) model_bank[i] = 12'd2048;
        model_dirty = 8'h00;
        rst_n = 1'b0; en = 1'b1; spi_sclk = 1'b0; spi_mosi = 1'b0; spi_cs_n = 1'b1;
        rd_pos = 3'd0; dirty_clr = 8'h00; rd_pos_s = 3'd0;
`ifdef DAC_REG_READBACK_EN
        rb_cap = 16'h0;
`endif

        // Per-cycle comparison against the model, plus pulse accounting
        fork
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    if (frame_done) n_done++;
                    if (frame_err)  n_err++;
                    if (frame_done && frame_err) chk("done_err_overlap", 32'd1, 32'd0);
                    if (frame_done && prev_done) chk("done_width", 32'd2, 32'd1);
                    if (frame_err && prev_err)   chk("err_width", 32'd2, 32'd1);
                    if (quiet) begin
                        chk("rd_data_model", 32'(rd_data), 32'(model_bank[rd_pos_s]));
                        chk("dirty_model", 32'(dirty), 32'(model_dirty));
                    end
                end
                prev_done = frame_done;
                prev_err  = frame_err;
            end
        join_none

        tick(3);
        chk("rst_rd_data", 32'(rd_data), 32'd2048);
        chk("rst_dirty", 32'(dirty), 32'h00);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_err", 32'(frame_err), 32'd0);
        rst_n = 1'b1;
        tick(2);

        for (int p = 0; p < 8; p++) read_chk("rst_bank", 3'(p), 12'd2048);
        chk("rst_dirty_post", 32'(dirty), 32'h00);
        chk_en = 1'b1;
        quiet = 1'b1;
        tick(2);

        // Valid frame to channel 3
        frame(32'h3ABC, 16);
        read_chk("bank3", 3'd3, 12'hABC);
        read_chk("bank2", 3'd2, 12'd2048);
        chk("dirty_3abc", 32'(dirty), 32'h08);
        chk("done_after_3abc", 32'(n_done), 32'd1);

        // Rejected frames: short, long, reserved bit set
        frame(32'h0_1234 >> 1, 15);
        frame(32'h1_2345, 17);
        frame(32'h8123, 16);
        chk("err_after_bad", 32'(n_err), 32'd3);
        chk("done_after_bad", 32'(n_done), 32'd1);
        chk("dirty_after_bad", 32'(dirty), 32'h08);
        read_chk("bank1_after_bad", 3'd1, 12'd2048);

        // Commit to ch5 coinciding with its dirty clear and a read of ch5
        quiet = 1'b0;
        rd_pos = 3'd5;
        spi_cs_n = 1'b0;
        tick(4);
        send_bits(32'h55A5, 16);
        tick(4);
        spi_cs_n = 1'b1;
        tick(3);
        dirty_clr = 8'h20;
        tick(1);
        dirty_clr = 8'h00;
        chk("coll_rd_old", 32'(rd_data), 32'd2048);
        chk("coll_dirty5", 32'(dirty[5]), 32'd1);
        tick(1);
        chk("coll_rd_new", 32'(rd_data), 32'h5A5);
        model_bank[5] = 12'h5A5;
        model_dirty[5] = 1'b1;
        exp_done++;
        tick(8);
        chk("coll_done_cnt", 32'(n_done), 32'(exp_done));
        chk("coll_dirty", 32'(dirty), 32'h28);
        quiet = 1'b1;
        tick(4);

        // Enable dropped mid-frame: silent discard
        quiet = 1'b0;
        spi_cs_n = 1'b0;
        tick(4);
        send_bits(32'hA5, 8);
        en = 1'b0;
        tick(4);
        en = 1'b1;
        tick(4);
        spi_cs_n = 1'b1;
        tick(10);
        chk("abort_err_cnt", 32'(n_err), 32'(exp_err));
        chk("abort_done_cnt", 32'(n_done), 32'(exp_done));
        quiet = 1'b1;
        tick(4);
        frame(32'h1001, 16);
        read_chk("bank1_after_abort", 3'd1, 12'h001);

        // Randomized frames and dirty clears
        rd_rand = 1'b1;
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            n = (r == 0) ? 15 : (r == 1) ? 17 : 16;
            v = $urandom;
            v = v & ((32'd1 << n) - 32'd1);
            frame(v, n);
            if ($urandom_range(0, 3) == 0) clear_dirty(8'($urandom));
        end
        rd_rand = 1'b0;

`ifdef DAC_REG_READBACK_EN
        frame(32'h6555, 16);
        rb_cap = 16'h0;
        frame(32'h0000, 16);
        chk("readback", 32'(rb_cap), 32'h0555);
`endif

        tick(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
